// File: rtl/quad_decoder.sv
// Quadrature encoder front end: sync, glitch filter, Gray decode, index load.
// Define QUAD_X4_EN for x4 resolution; default build counts x1 (into 00 only).
module quad_decoder #(
  parameter int FILTER_LEN  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8,
  parameter int INDEX_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             idx_in,
  input  logic             idx_arm,
  input  logic             clr_err,
  output logic             step,
  output logic             dir,
  output logic             index_pulse,
  output logic [WIDTH-1:0] load_value,
  output logic             err_pulse,
  output logic             err_flag,
  output logic             ready
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int NP = 3;

  state_t                 state;
  logic [NP-1:0]          raw;
  logic [NP-1:0]          s;
  logic [NP-1:0]          f;
  logic [SYNC_STAGES-1:0] sync_q [NP];
  logic [3:0]             cnt [NP];
  logic [2:0]             icnt;
  logic [1:0]             prev;
  logic [1:0]             cur;
  logic [1:0]             nxt_up;
  logic [1:0]             diff;
  logic                   iprev;
  logic                   legal;
  logic                   both;
  logic                   is_up;
  logic                   cnt_step;
  logic                   idx_rise;

  assign raw        = {idx_in, b_in, a_in};
  assign load_value = WIDTH'(INDEX_VALUE);
  assign cur        = {f[0], f[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) sync_q[p] <= '0;
    end else begin
      for (int p = 0; p < NP; p++)
        sync_q[p] <= {sync_q[p][SYNC_STAGES-2:0], raw[p]};
    end
  end

  always_comb begin
    s = '0;
    for (int p = 0; p < NP; p++) s[p] = sync_q[p][SYNC_STAGES-1];
  end

  always_comb begin
    nxt_up = 2'b00;
    case (prev)
      2'b00:   nxt_up = 2'b10;
      2'b10:   nxt_up = 2'b11;
      2'b11:   nxt_up = 2'b01;
      default: nxt_up = 2'b00;
    endcase
  end

  always_comb begin
    diff  = cur ^ prev;
    legal = ^diff;
    both  = &diff;
    is_up = (cur == nxt_up);
`ifdef QUAD_X4_EN
    cnt_step = legal;
`else
    cnt_step = legal && (cur == 2'b00);
`endif
    idx_rise = f[2] & ~iprev & idx_arm;
  end

  // Priming loads the filters straight from the synchronisers so that
  // stale pin history never decodes into a step after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      icnt        <= '0;
      f           <= '0;
      prev        <= '0;
      iprev       <= 1'b0;
      step        <= 1'b0;
      dir         <= 1'b0;
      index_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      err_flag    <= 1'b0;
      ready       <= 1'b0;
      for (int p = 0; p < NP; p++) cnt[p] <= '0;
    end else begin
      step        <= 1'b0;
      index_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      unique case (state)
        INIT: begin
          err_flag <= err_flag & ~clr_err;
          if (icnt == 3'(SYNC_STAGES)) begin
            f     <= s;
            prev  <= {s[0], s[1]};
            iprev <= s[2];
            ready <= 1'b1;
            state <= RUN;
          end else begin
            icnt <= icnt + 3'd1;
          end
        end
        RUN: begin
          for (int p = 0; p < NP; p++) begin
            if (s[p] == f[p]) begin
              cnt[p] <= '0;
            end else if (cnt[p] == 4'(FILTER_LEN - 1)) begin
              f[p]   <= s[p];
              cnt[p] <= '0;
            end else begin
              cnt[p] <= cnt[p] + 4'd1;
            end
          end
          prev        <= cur;
          iprev       <= f[2];
          step        <= cnt_step;
          if (cnt_step) dir <= is_up;
          err_pulse   <= both;
          err_flag    <= both | (err_flag & ~clr_err);
          index_pulse <= idx_rise;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature encoder front end that sits directly upstream of the 8-bit loadable up/down counter.
- Synchronises and glitch-filters raw A/B/index pins and decodes Gray-code transitions.
- Emits one-cycle step pulses with a direction bit, plus an index load pulse and its load value.
- Outputs map 1:1 onto the counter's en/up/load/load_value inputs; illegal transitions are flagged, not counted.

Parameters:
- FILTER_LEN, 4: consecutive stable cycles required before a filtered pin changes; legal range 1..15.
- SYNC_STAGES, 2: flip-flop depth of the input synchroniser on each pin; legal range 2..4.
- WIDTH, 8: width of load_value.
- INDEX_VALUE, 0: constant driven on load_value when index_pulse fires.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- a_in  in  1  raw encoder channel A, asynchronous to clk
- b_in  in  1  raw encoder channel B, asynchronous to clk
- idx_in  in  1  raw index pin, asynchronous to clk
- idx_arm  in  1  synchronous; 1 enables index_pulse generation
- clr_err  in  1  synchronous; clears err_flag
- step  out  1  one-cycle pulse per counted transition; drives counter en
- dir  out  1  1 = up (A leads B), 0 = down; valid when step=1; drives counter up
- index_pulse  out  1  one-cycle pulse on filtered idx rising edge; drives counter load
- load_value  out  WIDTH  constant INDEX_VALUE
- err_pulse  out  1  one-cycle pulse on an illegal transition
- err_flag  out  1  sticky error indication
- ready  out  1  1 once the priming state has finished

Behaviour:
- Reset values: step=0, dir=0, index_pulse=0, err_pulse=0, err_flag=0, ready=0.
- Reset also clears the synchronisers, filters, filter counters and FSM (to INIT). load_value is always INDEX_VALUE.
- Sync: each pin passes through SYNC_STAGES flops, giving the synced value s.
- Filter, per pin, with filtered value f and counter cnt:
  - If s==f: cnt<=0.
  - Else if cnt==FILTER_LEN-1: f<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - A mismatch that lasts fewer than FILTER_LEN cycles never reaches f.
- FSM INIT:
  - Counts SYNC_STAGES+1 cycles, then loads fA, fB, fI directly from s with no decode and no pulses.
  - Then sets ready=1 and moves to RUN.
  - All pulse outputs are 0 while in INIT.
- FSM RUN: decode runs on prev={fA,fB} vs cur={fA,fB} each cycle. Outputs are registered, so the pulse appears 1 cycle after f changes.
  - Up sequence: 00->10->11->01->00. Down is the reverse.
  - One bit changed: legal transition. dir=1 if it is the next up state, else dir=0.
  - Both bits changed: step=0, err_pulse=1, err_flag<=1.
  - No change: nothing.
- Total latency: a clean edge held on a pin produces step exactly SYNC_STAGES+FILTER_LEN+1 cycles after the first clk edge that samples the new level.
- Resolution without the optional feature (x1): step fires only on legal transitions into 00.
  - 01->00 gives dir=1.
  - 10->00 gives dir=0.
  - All other legal transitions update prev silently.
- Index: index_pulse=1 for one cycle when fI goes 0->1 and idx_arm=1.
  - idx_arm is sampled in the same cycle as the fI edge.
  - An edge seen while idx_arm=0 is discarded, not deferred.
  - index_pulse may coincide with step; the counter gives load priority.
- err_flag: set by err_pulse, cleared by clr_err. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all state returns to INIT immediately and no pulse is emitted in the reset cycle. After release, priming repeats, so no spurious step is generated from stale prev.

Optional Feature:
- Macro: QUAD_X4_EN.
- Defined: x4 resolution. Every legal transition produces step with its dir, giving 4 steps per encoder cycle.
- Undefined: x1 resolution as specified under Behaviour, giving 1 step per cycle.
- Error detection, index handling and latency are identical in both builds.

Test Plan:
- Reset, then hold A=B=idx=0; release reset -> ready rises after SYNC_STAGES+1=3 cycles; no step, err or index pulse.
- FILTER_LEN=4; drive one full up cycle 00->10->11->01->00 with each state held 10 cycles:
  - x1 build -> exactly 1 step with dir=1, 7 cycles after the final 01->00 edge.
  - QUAD_X4_EN build -> 4 steps, all dir=1.
- Same sequence reversed -> x1 gives 1 step with dir=0; x4 gives 4 steps with dir=0.
- 3-cycle glitch on A (shorter than FILTER_LEN=4) -> no filtered change, step=0 throughout.
- Switch A and B together (00->11), held 10 cycles -> err_pulse for 1 cycle, err_flag=1, no step.
  - Assert clr_err alone -> err_flag=0 next cycle.
  - clr_err coincident with a new error -> err_flag stays 1.
- Index checks:
  - idx_arm=1, idx 0->1 held 10 cycles -> 1 index_pulse with load_value=INDEX_VALUE=0.
  - idx_arm=0 -> no pulse.
  - Assert rst mid-filter -> all outputs 0 and ready=0 immediately; re-primes after release.
